// File: rtl/fifo_sram_scheduler.sv
// Round-robin scheduler for a single-port SRAM FIFO: arbitrates producer/consumer
// access, hides the SRAM read latency, issues flushes and tracks occupancy.
module fifo_sram_scheduler #(
   parameter int BUS_WIDTH = 8,
   parameter int RD_LAT    = 1,
   parameter int CNT_W     = 11
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 flush_req,
   input  logic                 wr_req,
   input  logic [BUS_WIDTH-1:0] wr_data,
   output logic                 wr_ack,
   input  logic                 rd_req,
   output logic                 rd_ack,
   output logic [BUS_WIDTH-1:0] rd_data,
   output logic                 rd_valid,
   input  logic                 fifo_full,
   input  logic                 fifo_empty,
   input  logic [BUS_WIDTH-1:0] fifo_data_o,
   output logic [BUS_WIDTH-1:0] fifo_data_i,
   output logic                 fifo_w_enable,
   output logic                 fifo_r_enable,
   output logic                 fifo_clear,
   output logic [CNT_W-1:0]     occupancy,
   output logic                 busy
);

   typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_RD_OUT, S_FLUSH} state_t;

   localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

   state_t               state_q, state_d;
   logic                 last_rd_q, last_rd_d;
   logic [1:0]           lat_cnt_q, lat_cnt_d;
   logic [BUS_WIDTH-1:0] rd_data_q, rd_data_d;
   logic [CNT_W-1:0]     occ_q, occ_d;

   logic w_elig, r_elig, arb_en, grant_w, grant_r, clear;

   always_comb begin
      w_elig  = wr_req & ~fifo_full;
      r_elig  = rd_req & ~fifo_empty;
      // Gating with n_rst keeps the Mealy acks low while reset is held.
      arb_en  = n_rst & ~flush_req & ((state_q == S_IDLE) | (state_q == S_RD_OUT));
      grant_w = arb_en & w_elig & (~r_elig | last_rd_q);
      grant_r = arb_en & r_elig & ~grant_w;
      clear   = (state_q == S_FLUSH);
   end

   always_comb begin
      state_d   = state_q;
      last_rd_d = last_rd_q;
      lat_cnt_d = lat_cnt_q;
      rd_data_d = rd_data_q;
      if (grant_w) last_rd_d = 1'b0;
      if (grant_r) last_rd_d = 1'b1;
      if (flush_req) begin
         state_d = S_FLUSH;
      end else begin
         case (state_q)
            S_IDLE, S_RD_OUT: begin
               state_d   = grant_r ? S_RD_WAIT : S_IDLE;
               lat_cnt_d = 2'd0;
            end
            S_RD_WAIT: begin
               if (lat_cnt_q == LAT_LAST) begin
                  rd_data_d = fifo_data_o;
                  state_d   = S_RD_OUT;
               end else begin
                  lat_cnt_d = lat_cnt_q + 2'd1;
               end
            end
            S_FLUSH: state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Counter saturates at both ends rather than wrapping.
   always_comb begin
      occ_d = occ_q;
      if (clear)
         occ_d = '0;
      else if (grant_w && (occ_q != '1))
         occ_d = occ_q + 1'b1;
      else if (grant_r && (occ_q != '0))
         occ_d = occ_q - 1'b1;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= S_IDLE;
         last_rd_q <= 1'b1;
         lat_cnt_q <= 2'd0;
         rd_data_q <= '0;
         occ_q     <= '0;
      end else begin
         state_q   <= state_d;
         last_rd_q <= last_rd_d;
         lat_cnt_q <= lat_cnt_d;
         rd_data_q <= rd_data_d;
         occ_q     <= occ_d;
      end
   end

   assign wr_ack        = grant_w;
   assign fifo_w_enable = grant_w;
   assign rd_ack        = grant_r;
   assign fifo_r_enable = grant_r;
   // A flush arriving in RD_OUT aborts the pending read's valid pulse.
   assign rd_valid      = n_rst & (state_q == S_RD_OUT) & ~flush_req;
   assign rd_data       = rd_data_q;
   assign fifo_clear    = clear;
   assign fifo_data_i   = wr_data;
   assign occupancy     = occ_q;
   assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_fifo_sram_scheduler.sv
// Directed bench for fifo_sram_scheduler: one RD_LAT=1 and one RD_LAT=3 instance
// share stimulus; read data and grant order are tracked through scoreboard queues.
module tb_fifo_sram_scheduler;

   logic       clk = 1'b0;
   logic       n_rst;
   logic       flush_req, wr_req, rd_req, fifo_full, fifo_empty;
   logic [7:0] wr_data, fifo_data_o;

   logic        wr_ack_1, rd_ack_1, rd_valid_1, fifo_w_enable_1, fifo_r_enable_1, fifo_clear_1, busy_1;
   logic [7:0]  rd_data_1, fifo_data_i_1;
   logic [10:0] occupancy_1;
   logic        wr_ack_3, rd_ack_3, rd_valid_3, fifo_w_enable_3, fifo_r_enable_3, fifo_clear_3, busy_3;
   logic [7:0]  rd_data_3, fifo_data_i_3;
   logic [10:0] occupancy_3;

   int vectors = 0;
   int errors  = 0;
   logic [7:0] data_q[$];
   int         grant_q[$];
   int         nv;
   int         g;

   always #5 clk = ~clk;

   fifo_sram_scheduler #(.BUS_WIDTH(8), .RD_LAT(1), .CNT_W(11)) u1 (
      .clk(clk), .n_rst(n_rst), .flush_req(flush_req),
      .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack_1),
      .rd_req(rd_req), .rd_ack(rd_ack_1), .rd_data(rd_data_1), .rd_valid(rd_valid_1),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_data_o(fifo_data_o),
      .fifo_data_i(fifo_data_i_1), .fifo_w_enable(fifo_w_enable_1),
      .fifo_r_enable(fifo_r_enable_1), .fifo_clear(fifo_clear_1),
      .occupancy(occupancy_1), .busy(busy_1)
   );

   fifo_sram_scheduler #(.BUS_WIDTH(8), .RD_LAT(3), .CNT_W(11)) u3 (
      .clk(clk), .n_rst(n_rst), .flush_req(flush_req),
      .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack_3),
      .rd_req(rd_req), .rd_ack(rd_ack_3), .rd_data(rd_data_3), .rd_valid(rd_valid_3),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_data_o(fifo_data_o),
      .fifo_data_i(fifo_data_i_3), .fifo_w_enable(fifo_w_enable_3),
      .fifo_r_enable(fifo_r_enable_3), .fifo_clear(fifo_clear_3),
      .occupancy(occupancy_3), .busy(busy_3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      flush_req   = 1'b0;
      wr_req      = 1'b0;
      rd_req      = 1'b0;
      fifo_full   = 1'b0;
      fifo_empty  = 1'b1;
      wr_data     = 8'h00;
      fifo_data_o = 8'h00;
   endtask

   task automatic do_reset();
      step();
      n_rst = 1'b0;
      clear_inputs();
      step();
      n_rst = 1'b1;
   endtask

   initial begin
      n_rst = 1'b0;
      clear_inputs();

      // reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_wr_ack", wr_ack_1, 0);
      chk("rst_rd_ack", rd_ack_1, 0);
      chk("rst_rd_valid", rd_valid_1, 0);
      chk("rst_clear", fifo_clear_1, 0);
      chk("rst_occ", occupancy_1, 0);
      chk("rst_busy", busy_1, 0);
      chk("rst_rd_data", rd_data_1, 0);
      step();
      n_rst = 1'b1;

      // three back-to-back writes
      wr_req  = 1'b1;
      wr_data = 8'hA5;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("wr_ack", wr_ack_1, 1);
         chk("wr_en", fifo_w_enable_1, 1);
         chk("wr_rd_en", fifo_r_enable_1, 0);
         chk("fifo_data_i", fifo_data_i_1, 8'hA5);
         step();
      end
      wr_req = 1'b0;
      @(negedge clk);
      chk("wr_ack_drop", wr_ack_1, 0);
      chk("occ_after_wr_1", occupancy_1, 3);
      chk("occ_after_wr_3", occupancy_3, 3);

      // single read, RD_LAT=1
      step();
      fifo_empty = 1'b0;
      rd_req     = 1'b1;
      @(negedge clk);
      chk("rd_ack", rd_ack_1, 1);
      chk("rd_en", fifo_r_enable_1, 1);
      chk("rd_wr_en", fifo_w_enable_1, 0);
      data_q.push_back(8'h3C);
      nv = 0;
      for (int k = 1; k <= 4; k++) begin
         step();
         rd_req      = 1'b0;
         fifo_data_o = (k == 1) ? 8'h3C : 8'h00;
         @(negedge clk);
         if (k == 1) chk("rd_wait_busy", busy_1, 1);
         if (rd_valid_1) begin
            nv++;
            chk("rd_latency", k, 2);
            if (data_q.size() > 0) chk("rd_data", rd_data_1, data_q.pop_front());
         end
      end
      chk("rd_valid_count", nv, 1);
      chk("rd_sb_drained", data_q.size(), 0);
      chk("rd_data_hold", rd_data_1, 8'h3C);
      chk("occ_after_rd", occupancy_1, 2);

      // round-robin alternation under continuous contention
      do_reset();
      wr_req     = 1'b1;
      rd_req     = 1'b1;
      fifo_empty = 1'b0;
      grant_q.push_back(1);
      grant_q.push_back(2);
      grant_q.push_back(1);
      grant_q.push_back(2);
      for (int c = 0; c < 20 && grant_q.size() > 0; c++) begin
         @(negedge clk);
         chk("no_dual_en_1", fifo_w_enable_1 & fifo_r_enable_1, 0);
         chk("no_dual_en_3", fifo_w_enable_3 & fifo_r_enable_3, 0);
         if (wr_ack_1 || rd_ack_1) begin
            g = wr_ack_1 ? 1 : 2;
            chk("grant_order", g, grant_q.pop_front());
         end
         step();
      end
      chk("grant_seq_done", grant_q.size(), 0);
      wr_req = 1'b0;
      rd_req = 1'b0;

      // full / empty block requests
      do_reset();
      wr_req = 1'b1;
      step();
      step();
      fifo_full  = 1'b1;
      fifo_empty = 1'b1;
      rd_req     = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("full_wr_ack", wr_ack_1, 0);
         chk("empty_rd_ack", rd_ack_1, 0);
         chk("blocked_occ", occupancy_1, 2);
         step();
      end
      clear_inputs();

      // flush during RD_WAIT (RD_LAT=3)
      do_reset();
      wr_req = 1'b1;
      step();
      step();
      wr_req     = 1'b0;
      fifo_empty = 1'b0;
      rd_req     = 1'b1;
      @(negedge clk);
      chk("fl_rd_ack", rd_ack_3, 1);
      step();
      rd_req = 1'b0;
      @(negedge clk);
      chk("fl_wait_busy", busy_3, 1);
      step();
      flush_req = 1'b1;
      @(negedge clk);
      chk("fl_no_ack", rd_ack_3, 0);
      chk("fl_clear_early", fifo_clear_3, 0);
      chk("fl_abort_valid_1", rd_valid_1, 0);
      step();
      flush_req = 1'b0;
      @(negedge clk);
      chk("fl_clear_3", fifo_clear_3, 1);
      chk("fl_clear_1", fifo_clear_1, 1);
      step();
      @(negedge clk);
      chk("fl_clear_once", fifo_clear_3, 0);
      chk("fl_occ_3", occupancy_3, 0);
      chk("fl_occ_1", occupancy_1, 0);
      chk("fl_busy", busy_3, 0);
      for (int i = 0; i < 6; i++) begin
         step();
         @(negedge clk);
         chk("fl_no_valid_3", rd_valid_3, 0);
         chk("fl_no_valid_1", rd_valid_1, 0);
      end

      // reset asserted during RD_WAIT
      do_reset();
      wr_req = 1'b1;
      step();
      wr_req      = 1'b0;
      fifo_empty  = 1'b0;
      fifo_data_o = 8'h77;
      rd_req      = 1'b1;
      @(negedge clk);
      chk("rr_rd_ack", rd_ack_3, 1);
      step();
      rd_req = 1'b0;
      @(negedge clk);
      chk("rr_wait_busy", busy_3, 1);
      step();
      n_rst  = 1'b0;
      wr_req = 1'b1;
      rd_req = 1'b1;
      @(negedge clk);
      chk("rr_wr_ack", wr_ack_3, 0);
      chk("rr_rd_ack0", rd_ack_3, 0);
      chk("rr_wr_en", fifo_w_enable_3, 0);
      chk("rr_busy", busy_3, 0);
      chk("rr_valid", rd_valid_3, 0);
      chk("rr_rd_data", rd_data_3, 0);
      chk("rr_occ", occupancy_3, 0);
      step();
      n_rst = 1'b1;
      @(negedge clk);
      chk("rr_first_tie_w", wr_ack_3, 1);
      chk("rr_first_tie_r", rd_ack_3, 0);
      chk("rr_data_i", fifo_data_i_3, wr_data);
      step();
      wr_req = 1'b0;
      rd_req = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("rr_no_valid", rd_valid_3, 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
